// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state encoding and sizing helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned DEF_WIDTH = 32;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // Iteration counter must hold the value WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module muldiv_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dbit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             qbit
);

   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;

   always_comb begin
      partial = {rem_in, dbit};
      diff    = partial - {1'b0, divisor};
      qbit    = ~diff[WIDTH];
      // rem_in < divisor keeps the kept remainder within WIDTH bits
      rem_out = qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/DIV unit owning HI/LO; responds to MIPS funct requests from EX.
// Optional: define MULDIV_FAST_MULT_EN for a single-cycle combinational multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   output logic             Ready,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] RdResult,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam int unsigned W2 = 2 * WIDTH;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [W2-1:0]    acc, acc_n;
   logic [WIDTH-1:0] opb, opb_n;
   logic             op_div, op_div_n;
   logic             neg_q, neg_q_n;
   logic             neg_r, neg_r_n;
   logic             dbz, dbz_n;
   logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n, rd_q, rd_n;
   logic             done_q, done_n;
   logic             busy_q, ready_q;

   logic             is_signed;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] div_rem;
   logic             div_qbit;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc[W2-1:WIDTH]),
      .dbit    (acc[WIDTH-1]),
      .divisor (opb),
      .rem_out (div_rem),
      .qbit    (div_qbit)
   );

   // Operand magnitudes, one shift-add step, and the final sign correction.
   always_comb begin
      is_signed = (Funct == FN_MULT) || (Funct == FN_DIV);
      a_abs     = (is_signed && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
      b_abs     = (is_signed && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;
      mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      prod_fix  = neg_q ? -acc : acc;
      quo_fix   = dbz ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      rem_fix   = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [W2-1:0] fast_prod;

   always_comb begin
      fast_prod = {{WIDTH{is_signed & Rdata1[WIDTH-1]}}, Rdata1}
                * {{WIDTH{is_signed & Rdata2[WIDTH-1]}}, Rdata2};
   end
`endif

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      acc_n    = acc;
      opb_n    = opb;
      op_div_n = op_div;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      dbz_n    = dbz;
      hi_n     = hi_q;
      lo_n     = lo_q;
      rd_n     = rd_q;
      done_n   = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (Start) begin
               unique case (Funct)
                  FN_MTHI: begin
                     hi_n   = Rdata1;
                     done_n = 1'b1;
                  end
                  FN_MTLO: begin
                     lo_n   = Rdata1;
                     done_n = 1'b1;
                  end
                  FN_MFHI: begin
                     rd_n   = hi_q;
                     done_n = 1'b1;
                  end
                  FN_MFLO: begin
                     rd_n   = lo_q;
                     done_n = 1'b1;
                  end
                  FN_MULT, FN_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                     {hi_n, lo_n} = fast_prod;
                     done_n       = 1'b1;
`else
                     acc_n    = {{WIDTH{1'b0}}, b_abs};
                     opb_n    = a_abs;
                     op_div_n = 1'b0;
                     neg_q_n  = is_signed && (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                     neg_r_n  = 1'b0;
                     dbz_n    = 1'b0;
                     cnt_n    = CW'(WIDTH);
                     state_n  = S_MUL;
`endif
                  end
                  FN_DIV, FN_DIVU: begin
                     acc_n    = {{WIDTH{1'b0}}, a_abs};
                     opb_n    = b_abs;
                     op_div_n = 1'b1;
                     neg_q_n  = is_signed && (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                     neg_r_n  = is_signed && Rdata1[WIDTH-1];
                     dbz_n    = (Rdata2 == '0);
                     cnt_n    = CW'(WIDTH);
                     state_n  = S_DIV;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_n = {mul_sum, acc[WIDTH-1:1]};
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) state_n = S_FIX;
         end
         S_DIV: begin
            acc_n = {div_rem, acc[WIDTH-2:0], div_qbit};
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) state_n = S_FIX;
         end
         S_FIX: begin
            if (op_div) begin
               hi_n = rem_fix;
               lo_n = quo_fix;
            end else begin
               {hi_n, lo_n} = prod_fix;
            end
            done_n  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         opb     <= '0;
         op_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dbz     <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         rd_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         acc     <= acc_n;
         opb     <= opb_n;
         op_div  <= op_div_n;
         neg_q   <= neg_q_n;
         neg_r   <= neg_r_n;
         dbz     <= dbz_n;
         hi_q    <= hi_n;
         lo_q    <= lo_n;
         rd_q    <= rd_n;
         done_q  <= done_n;
         busy_q  <= (state_n != S_IDLE);
         ready_q <= (state_n == S_IDLE);
      end
   end

   assign Ready    = ready_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign RdResult = rd_q;
   assign Hi       = hi_q;
   assign Lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Start = 1'b0;
   logic [5:0]  Funct = '0;
   logic [31:0] Rdata1 = '0;
   logic [31:0] Rdata2 = '0;
   logic        Ready, Busy, Done;
   logic [31:0] RdResult, Hi, Lo;

   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   logic [31:0] exp_rd = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .Start    (Start),
      .Funct    (Funct),
      .Rdata1   (Rdata1),
      .Rdata2   (Rdata2),
      .Ready    (Ready),
      .Busy     (Busy),
      .Done     (Done),
      .RdResult (RdResult),
      .Hi       (Hi),
      .Lo       (Lo)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: architectural result of one request, straight from the arithmetic rules.
   task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int elat, output int ebusy);
      logic [63:0] r;
      int sa, sb;
      elat  = 34;
      ebusy = 33;
      sa    = $signed(a);
      sb    = $signed(b);
      case (f)
         F_MTHI: begin exp_hi = a; elat = 1; ebusy = 0; end
         F_MTLO: begin exp_lo = a; elat = 1; ebusy = 0; end
         F_MFHI: begin exp_rd = exp_hi; elat = 1; ebusy = 0; end
         F_MFLO: begin exp_rd = exp_lo; elat = 1; ebusy = 0; end
         F_MULTU, F_MULT: begin
            if (f == F_MULTU) r = {32'h0, a} * {32'h0, b};
            else              r = 64'(longint'(sa) * longint'(sb));
            {exp_hi, exp_lo} = r;
`ifdef MULDIV_FAST_MULT_EN
            elat  = 1;
            ebusy = 0;
`endif
         end
         F_DIVU: begin
            if (b == 0) begin exp_hi = a; exp_lo = 32'hFFFF_FFFF; end
            else begin exp_hi = a % b; exp_lo = a / b; end
         end
         F_DIV: begin
            if (b == 0) begin
               exp_hi = a; exp_lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               exp_hi = 32'h0; exp_lo = 32'h8000_0000;
            end else begin
               exp_hi = 32'(sa % sb);
               exp_lo = 32'(sa / sb);
            end
         end
         default: begin elat = -1; ebusy = 0; end
      endcase
   endtask

   // Called at a negedge; request is sampled at the following posedge.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      Start  = 1'b1;
      Funct  = f;
      Rdata1 = a;
      Rdata2 = b;
      @(posedge CLK);
      #1 Start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int lat, output int busy_cyc);
      bit seen = 0;
      lat      = 0;
      busy_cyc = 0;
      while (!seen && lat < 200) begin
         @(negedge CLK);
         lat++;
         if (Busy) busy_cyc++;
         if (Ready !== ~Busy) check({tag, "_ready_vs_busy"}, 64'(Ready), 64'(~Busy));
         if (Done) seen = 1;
      end
      if (!seen) check({tag, "_done_timeout"}, 64'(0), 64'(1));
   endtask

   task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
      int elat, ebusy, lat, bc;
      model_op(f, a, b, elat, ebusy);
      issue(f, a, b);
      wait_done(tag, lat, bc);
      check({tag, "_latency"}, 64'(lat), 64'(elat));
      check({tag, "_busy_cycles"}, 64'(bc), 64'(ebusy));
      check({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
      check({tag, "_rdresult"}, 64'(RdResult), 64'(exp_rd));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bc, elat, ebusy, dones;
      logic [5:0] fset [8];
      fset = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check("reset_hi", 64'(Hi), 64'(0));
      check("reset_lo", 64'(Lo), 64'(0));
      check("reset_rdresult", 64'(RdResult), 64'(0));
      check("reset_busy", 64'(Busy), 64'(0));
      check("reset_done", 64'(Done), 64'(0));
      check("reset_ready", 64'(Ready), 64'(1));

      do_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7);
      do_op("div_neg7by2", F_DIV, 32'hFFFF_FFF9, 32'd2);
      do_op("divu_7by2", F_DIVU, 32'd7, 32'd2);
      do_op("div_by_zero", F_DIV, 32'd5, 32'd0);
      do_op("divu_by_zero", F_DIVU, 32'h8765_4321, 32'd0);
      do_op("div_neg_by_zero", F_DIV, 32'hFFFF_FF00, 32'd0);
      do_op("div_overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("mult_minint", F_MULT, 32'h8000_0000, 32'h8000_0000);
      do_op("mthi", F_MTHI, 32'h0000_1234, 32'd0);
      do_op("mfhi", F_MFHI, 32'd0, 32'd0);
      do_op("mtlo", F_MTLO, 32'hCAFE_F00D, 32'd0);
      do_op("mflo", F_MFLO, 32'd0, 32'd0);

      // Start during Busy must be dropped without touching HI/LO.
      model_op(F_DIVU, 32'd100, 32'd7, elat, ebusy);
      issue(F_DIVU, 32'd100, 32'd7);
      repeat (4) @(negedge CLK);
      issue(F_MULT, 32'd3, 32'd3);
      wait_done("busy_ignore", lat, bc);
      check("busy_ignore_latency", 64'(lat + 4), 64'(elat));
      check("busy_ignore_hi", 64'(Hi), 64'(exp_hi));
      check("busy_ignore_lo", 64'(Lo), 64'(exp_lo));
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (Done) dones++;
      end
      check("busy_ignore_no_extra_done", 64'(dones), 64'(0));

      // Unknown funct is ignored entirely.
      issue(6'h20, 32'h1111_1111, 32'h2222_2222);
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (Done || Busy) dones++;
      end
      check("unknown_funct_no_done", 64'(dones), 64'(0));
      check("unknown_funct_hi", 64'(Hi), 64'(exp_hi));
      check("unknown_funct_lo", 64'(Lo), 64'(exp_lo));

      // Reset in cycle k+10 of a DIVU.
      issue(F_DIVU, 32'd1000, 32'd3);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      exp_rd = '0;
      check("midrst_busy", 64'(Busy), 64'(0));
      check("midrst_ready", 64'(Ready), 64'(1));
      check("midrst_hi", 64'(Hi), 64'(0));
      check("midrst_lo", 64'(Lo), 64'(0));
      dones = 0;
      repeat (40) begin
         @(negedge CLK);
         if (Done) dones++;
      end
      check("midrst_no_done", 64'(dones), 64'(0));
      do_op("after_reset_divu", F_DIVU, 32'd1000, 32'd3);

      for (int i = 0; i < 40; i++) begin
         logic [5:0]  f;
         logic [31:0] a, b;
         f = fset[$urandom_range(7, 0)];
         a = $urandom;
         b = $urandom;
         case ($urandom_range(7, 0))
            0: b = 32'd0;
            1: b = 32'(b[7:0]);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         do_op($sformatf("rand%0d", i), f, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
